// File: rtl/st7789_pkg.sv
// -----------------------------------------------------------------------------
// st7789_pkg
// Shared constants and types for the ST7789 SPI receive path.
//   - Command opcodes that the decoder recognises.
//   - Decoder state enumeration.
// -----------------------------------------------------------------------------
package st7789_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR,
        ST_OTHER
    } dec_state_t;

endpackage

// File: rtl/st7789_spi_deser.sv
// -----------------------------------------------------------------------------
// st7789_spi_deser
// Synchronises the SPI pins into the system clock domain, detects SCL rising
// edges and assembles MSB-first bytes.
//   i_clk, i_rst   : system clock, synchronous active-high reset
//   i_scl/i_sda    : SPI clock (idles high) and data
//   i_dc, i_resN   : data/command select, display reset (active low)
//   o_resN         : synchronised display reset
//   o_byteDone     : combinational strobe in the cycle the 8th edge is seen
//   o_byte/o_byteDc: byte and DC being completed by o_byteDone
//   o_rxValid/o_rxData/o_rxDc : registered byte report, one cycle later
// -----------------------------------------------------------------------------
module st7789_spi_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    input  logic       i_dc,
    input  logic       i_resN,
    output logic       o_resN,
    output logic       o_byteDone,
    output logic [7:0] o_byte,
    output logic       o_byteDc,
    output logic       o_rxValid,
    output logic [7:0] o_rxData,
    output logic       o_rxDc
);

    // Pin bundle order {resN, dc, sda, scl}; idle value keeps SCL high and the
    // display out of reset so leaving rst_i never fakes an edge.
    localparam logic [3:0] SYNC_IDLE = 4'b1001;

    logic [3:0] w_pins;
    logic [3:0] w_synced;
    logic       w_scl;
    logic       w_sda;
    logic       w_dc;
    logic       w_rise;
    logic       r_sclPrev;
    logic [2:0] r_bitCnt;
    logic [6:0] r_shift;

    assign w_pins = {i_resN, i_dc, i_sda, i_scl};

    // All four pins share one synchroniser depth so DC and SDA stay aligned
    // with the SCL edge that samples them.
    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign w_synced = w_pins;
        end else begin : g_sync
            logic [3:0] r_sync [SYNC_STAGES];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= SYNC_IDLE;
                    end
                end else begin
                    r_sync[0] <= w_pins;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_synced = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_scl  = w_synced[0];
    assign w_sda  = w_synced[1];
    assign w_dc   = w_synced[2];
    assign o_resN = w_synced[3];
    assign w_rise = w_scl & ~r_sclPrev;

    // A byte completes on the 8th rising edge unless display reset is active
    // in that same cycle.
    assign o_byteDone = w_rise && (r_bitCnt == 3'd7) && o_resN;
    assign o_byte     = {r_shift, w_sda};
    assign o_byteDc   = w_dc;

    // Shift register and bit counter; the counter wraps naturally after 8.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclPrev <= 1'b1;
            r_bitCnt  <= 3'd0;
            r_shift   <= 7'd0;
            o_rxValid <= 1'b0;
            o_rxData  <= 8'd0;
            o_rxDc    <= 1'b0;
        end else begin
            r_sclPrev <= w_scl;
            o_rxValid <= 1'b0;
            if (!o_resN) begin
                r_bitCnt <= 3'd0;
            end else if (w_rise) begin
                r_shift  <= o_byte[6:0];
                r_bitCnt <= r_bitCnt + 3'd1;
                if (r_bitCnt == 3'd7) begin
                    o_rxValid <= 1'b1;
                    o_rxData  <= o_byte;
                    o_rxDc    <= w_dc;
                end
            end
        end
    end

endmodule

// File: rtl/st7789_spi_rx.sv
// -----------------------------------------------------------------------------
// st7789_spi_rx
// Receive side of the ST7789 4-wire SPI link. Decodes CASET/RASET/RAMWR and
// produces RGB565 pixel writes with {y,x} frame-buffer addresses.
//   clk_i, rst_i            : system clock, synchronous active-high reset
//   scl_i, sda_i, dc_i      : SPI clock/data and data/command select
//   res_ni                  : display reset, active low
//   rx_valid_o/data/dc      : per-byte report
//   pix_we_o/addr/data      : pixel write port, frame_o on last window pixel
//   last_cmd_o              : most recent command byte
// -----------------------------------------------------------------------------
module st7789_spi_rx
    import st7789_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEF_END     = 239
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        scl_i,
    input  logic        sda_i,
    input  logic        dc_i,
    input  logic        res_ni,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_dc_o,
    output logic        pix_we_o,
    output logic [15:0] pix_addr_o,
    output logic [15:0] pix_data_o,
    output logic        frame_o,
    output logic [7:0]  last_cmd_o
);

    localparam logic [7:0] DEF_END_B = 8'(DEF_END);

    logic       w_resN;
    logic       w_byteDone;
    logic [7:0] w_byte;
    logic       w_byteDc;

    dec_state_t r_state;
    dec_state_t w_nextState;
    logic [1:0] r_paramIdx;
    logic [7:0] r_xs;
    logic [7:0] r_xe;
    logic [7:0] r_ys;
    logic [7:0] r_ye;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic       r_hiValid;
    logic [7:0] r_hi;

    st7789_spi_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .i_dc       (dc_i),
        .i_resN     (res_ni),
        .o_resN     (w_resN),
        .o_byteDone (w_byteDone),
        .o_byte     (w_byte),
        .o_byteDc   (w_byteDc),
        .o_rxValid  (rx_valid_o),
        .o_rxData   (rx_data_o),
        .o_rxDc     (rx_dc_o)
    );

    // last_cmd_o is taken from the unregistered byte so it lands in the same
    // cycle as rx_valid_o.
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_resN) begin
            last_cmd_o <= 8'd0;
        end else if (w_byteDone && !w_byteDc) begin
            last_cmd_o <= w_byte;
        end
    end

    // Decoder state register.
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_resN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: any command restarts decoding; window commands fall back to
    // IDLE once their fourth parameter is consumed.
    always_comb begin
        w_nextState = r_state;
        if (rx_valid_o) begin
            if (!rx_dc_o) begin
                case (rx_data_o)
                    CMD_CASET: w_nextState = ST_CASET;
                    CMD_RASET: w_nextState = ST_RASET;
                    CMD_RAMWR: w_nextState = ST_RAMWR;
                    default:   w_nextState = ST_OTHER;
                endcase
            end else if ((r_state == ST_CASET || r_state == ST_RASET)
                         && r_paramIdx == 2'd3) begin
                w_nextState = ST_IDLE;
            end
        end
    end

    // Window, cursor and pixel assembly. The decoder works on the registered
    // byte report, which places pixel writes one cycle after rx_valid_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_paramIdx <= 2'd0;
            r_xs       <= 8'd0;
            r_xe       <= DEF_END_B;
            r_ys       <= 8'd0;
            r_ye       <= DEF_END_B;
            r_x        <= 8'd0;
            r_y        <= 8'd0;
            r_hiValid  <= 1'b0;
            r_hi       <= 8'd0;
            pix_we_o   <= 1'b0;
            pix_addr_o <= 16'd0;
            pix_data_o <= 16'd0;
            frame_o    <= 1'b0;
        end else begin
            pix_we_o <= 1'b0;
            frame_o  <= 1'b0;
            if (!w_resN) begin
                r_paramIdx <= 2'd0;
                r_xs       <= 8'd0;
                r_xe       <= DEF_END_B;
                r_ys       <= 8'd0;
                r_ye       <= DEF_END_B;
                r_x        <= 8'd0;
                r_y        <= 8'd0;
                r_hiValid  <= 1'b0;
                r_hi       <= 8'd0;
            end else if (rx_valid_o) begin
                if (!rx_dc_o) begin
                    // A command drops any half-received pixel.
                    r_paramIdx <= 2'd0;
                    r_hiValid  <= 1'b0;
                    if (rx_data_o == CMD_SWRESET) begin
                        r_xs <= 8'd0;
                        r_xe <= DEF_END_B;
                        r_ys <= 8'd0;
                        r_ye <= DEF_END_B;
                    end
                    if (rx_data_o == CMD_RAMWR) begin
                        r_x <= r_xs;
                        r_y <= r_ys;
                    end
                end else begin
                    case (r_state)
                        ST_CASET: begin
                            r_paramIdx <= r_paramIdx + 2'd1;
                            if (r_paramIdx == 2'd1) r_xs <= rx_data_o;
                            if (r_paramIdx == 2'd3) r_xe <= rx_data_o;
                        end
                        ST_RASET: begin
                            r_paramIdx <= r_paramIdx + 2'd1;
                            if (r_paramIdx == 2'd1) r_ys <= rx_data_o;
                            if (r_paramIdx == 2'd3) r_ye <= rx_data_o;
                        end
                        ST_RAMWR: begin
                            if (!r_hiValid) begin
                                r_hi      <= rx_data_o;
                                r_hiValid <= 1'b1;
                            end else begin
                                r_hiValid  <= 1'b0;
                                pix_we_o   <= 1'b1;
                                pix_addr_o <= {r_y, r_x};
                                pix_data_o <= {r_hi, rx_data_o};
                                frame_o    <= (r_x == r_xe) && (r_y == r_ye);
                                // 8-bit increments give the modulo-256 walk
                                // needed for inverted windows.
                                if (r_x == r_xe) begin
                                    r_x <= r_xs;
                                    if (r_y == r_ye) begin
                                        r_y <= r_ys;
                                    end else begin
                                        r_y <= r_y + 8'd1;
                                    end
                                end else begin
                                    r_x <= r_x + 8'd1;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
